fsm_rr_arbiter: RTL



---
 rtl/fsm_rr_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/fsm_rr_arbiter.sv
// Purpose : round-robin arbiter giving one shared resource to one of NUM_REQ requesters, with an optional hold limit.
// Latency : 1 cycle from a sampled request or release to the registered grant; a handoff leaves no idle cycle.
// Backpr. : no ready input. Requests are level-sensitive and are not latched; the owner keeps the grant while it requests.
//
// Ports:
//   clock     in   system clock; all state updates on the rising edge
//   reset_n   in   asynchronous active-low reset
//   req       in   [NUM_REQ-1:0] request vector, bit i = requester i
//   gnt       out  [NUM_REQ-1:0] registered one-hot grant, or all-zero
//   gnt_valid out  registered, equal to |gnt
//   gnt_id    out  [ID_W-1:0] registered owner index; keeps its last value when idle
//
// Build option: define ARB_HOLD_LIMIT_EN to add the hold counter. When
// another request is pending, it pre-empts an owner after MAX_HOLD
// consecutive grant cycles.
module fsm_rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 8,
  parameter int ID_W     = $clog2(NUM_REQ)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [ID_W-1:0]    gnt_id
);

  // Catch illegal parameter values at elaboration time.
  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
    $error("fsm_rr_arbiter: NUM_REQ must be in 2..16");
  end
  if (MAX_HOLD < 1) begin : g_bad_max_hold
    $error("fsm_rr_arbiter: MAX_HOLD must be >= 1");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [ID_W-1:0]    last_id, last_id_nxt;
  logic [ID_W-1:0]    gnt_id_nxt;
  logic [NUM_REQ-1:0] gnt_nxt;
  logic [NUM_REQ-1:0] cand;
  logic [ID_W-1:0]    scan_id;
  logic [ID_W-1:0]    win_id;
  logic               win_found;
  logic               owner_req;
  logic               limit_hit;
  logic               take_win;

  // The current owner never competes for its own successor. A released
  // owner has req=0 anyway. A pre-empted owner must lose to any other
  // pending requester. In IDLE, gnt is zero, so every request is a candidate.
  assign cand      = req & ~gnt;
  assign owner_req = req[gnt_id];

  // Round-robin search: last_id+1, last_id+2, ... modulo NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_id    = last_id;
    scan_id   = last_id;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_id = ID_W'((int'(last_id) + k) % NUM_REQ);
      if (!win_found && cand[scan_id]) begin
        win_found = 1'b1;
        win_id    = scan_id;
      end
    end
  end

`ifdef ARB_HOLD_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  logic [CNT_W-1:0] cnt;
  logic             keep;
  logic             renew;

  assign limit_hit = (cnt == CNT_W'(MAX_HOLD));
  assign keep      = (state == GRANT) && owner_req && !limit_hit;
  // At the limit with nobody else waiting, the owner starts a fresh hold window.
  assign renew     = (state == GRANT) && owner_req && limit_hit && !win_found;

  // keep is false at the limit, so the counter saturates at MAX_HOLD and never wraps.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (take_win || renew) begin
      cnt <= CNT_W'(1);
    end else if (keep) begin
      cnt <= cnt + CNT_W'(1);
    end
  end
`else
  assign limit_hit = 1'b0;
`endif

  // Next-state and output logic.
  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    gnt_id_nxt  = gnt_id;
    last_id_nxt = last_id;
    take_win    = 1'b0;

    case (state)
      IDLE: begin
        if (win_found) begin
          take_win = 1'b1;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          if (win_found) begin
            take_win = 1'b1;          // hand off directly, no idle cycle
          end else begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
          end
        end else if (limit_hit && win_found) begin
          take_win = 1'b1;            // hold limit pre-empts the owner
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase

    if (take_win) begin
      state_nxt       = GRANT;
      gnt_nxt         = '0;
      gnt_nxt[win_id] = 1'b1;
      gnt_id_nxt      = win_id;
      last_id_nxt     = win_id;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      last_id   <= ID_W'(NUM_REQ - 1);
    end else begin
      state     <= state_nxt;
      gnt       <= gnt_nxt;
      gnt_valid <= |gnt_nxt;
      gnt_id    <= gnt_id_nxt;
      last_id   <= last_id_nxt;
    end
  end

endmodule
